dx_hazard_ctrl: RTL and testbench
=================================

Name: dx_hazard_ctrl

Overview:
- Control end of the decode->execute pipeline register: decides whether the FD instruction advances into DX, is held, or is replaced by a bubble.
- Tracks in-flight register writers in a 3-slot scoreboard (DX, XM, MW) and detects RAW hazards against the decode-stage sources.
- Drives pc/FD stall, DX bubble insert and FD flush. Honours branch redirect from X and memory-stage stalls.

Parameters:
- REG_AW, 3, register address width (8 GPRs, r0 is an ordinary register).
- CNT_W, 8, width of the saturating hazard-stall counter.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous active-low reset
- fd_valid  input  1  FD stage holds a real instruction
- fd_rs  input  REG_AW  source register 1
- fd_rs_used  input  1  instruction reads fd_rs
- fd_rt  input  REG_AW  source register 2
- fd_rt_used  input  1  instruction reads fd_rt
- fd_wr_en  input  1  instruction writes a register
- fd_wr_reg  input  REG_AW  destination register
- fd_is_load  input  1  instruction is a memory load
- br_taken  input  1  X-stage redirect (branch/jump resolved taken)
- mem_stall  input  1  memory stage busy; freeze the pipe
- pc_stall  output  1  hold PC
- fd_stall  output  1  hold the FD register
- dx_bubble  output  1  load a NOP (all controls 0) into the DX register
- fd_flush  output  1  kill the FD instruction
- hazard_cnt  output  CNT_W  cycles lost to data hazards

Behaviour:
- Reset: rst=0 at a clock edge clears all slot valids and hazard_cnt to 0. While rst=0, all combinational outputs are forced to 0.
- Scoreboard slot fields: valid, wr_reg, is_load. A slot is valid only if its instruction had fd_wr_en=1.
- Match on a source: (rs_used & rs==slot.wr_reg) | (rt_used & rt==slot.wr_reg), with slot.valid=1.
- raw_haz (without forwarding): fd_valid & (match DX | match XM). MW is not checked; the regfile bypasses write-to-read in the same cycle.
- Output priority, highest first:
  1. mem_stall=1: pc_stall=fd_stall=1, dx_bubble=0, fd_flush=0, scoreboard held, counter held.
  2. br_taken=1: fd_flush=1, dx_bubble=1, pc_stall=fd_stall=0. The DX slot is loaded empty and the shift proceeds. raw_haz is ignored.
  3. raw_haz=1: pc_stall=fd_stall=dx_bubble=1. The DX slot is loaded empty and the shift proceeds. hazard_cnt increments.
  4. Otherwise: all outputs 0. The DX slot is loaded from FD (valid = fd_valid & fd_wr_en).
- Shift whenever mem_stall=0: MW<=XM, XM<=DX, DX<=new entry.
- Latency:
  - A dependent instruction stalls at most 2 cycles behind a non-load producer.
  - Stall outputs are combinational from registered state plus current inputs, with no added latency.
- hazard_cnt saturates at 2^CNT_W-1 and never wraps.
- Simultaneous br_taken and raw_haz: flush wins and the counter does not increment.
- Simultaneous mem_stall and br_taken: freeze wins; br_taken must be held by X until mem_stall drops.
- fd_valid=0: no hazard, no count. Empty slot inserted when wr_en=0.
- Reset mid-stall: all state cleared; the next cycle issues normally.

Optional Feature:
- Macro: DX_HAZARD_FORWARDING_EN
- Defined: the execute stage forwards from XM and MW. raw_haz = fd_valid & match DX & DX.is_load (load-use only), giving exactly 1 stall cycle.
- Undefined: raw_haz as above (DX or XM match, no is_load qualification). is_load is still stored but unused.

Test Plan:
- Reset, then fd_valid=1 rs=3 rt=4 used, no writers in flight -> all outputs 0; hazard_cnt=0 after 10 cycles.
- Issue ADD wr_reg=2, then next cycle an instruction reading rs=2 (no forwarding) -> stall/bubble high for 2 cycles, issues on the 3rd; hazard_cnt=2.
- With DX_HAZARD_FORWARDING_EN: LD wr_reg=5, then a reader of rt=5 -> exactly 1 stall cycle, hazard_cnt=1. ADD wr_reg=5 followed by the same reader -> 0 stalls.
- Hazard pending with br_taken=1 in the same cycle -> fd_flush=1, dx_bubble=1, pc_stall=0, hazard_cnt unchanged.
- Producer in DX, mem_stall=1 for 3 cycles -> pc_stall=fd_stall=1, dx_bubble=0, scoreboard unchanged. Afterwards the hazard resolves with the same stall count as without mem_stall.
- CNT_W=2, force 5 hazard cycles -> hazard_cnt stops at 3. Assert rst=0 during a stall -> outputs 0 that cycle; hazard_cnt=0 and slots empty after the edge.

Source files
------------

// File: rtl/dx_hazard_if.sv
// dx_hazard_if
//   Bundle of the decode-stage request signals and the pipeline control
//   responses exchanged between the FD/X stages and dx_hazard_ctrl.
//
//   master : drives the decode-stage instruction fields, br_taken, mem_stall;
//            observes pc_stall/fd_stall/dx_bubble/fd_flush/hazard_cnt.
//   slave  : the hazard controller (opposite directions).
//
//   REG_AW : register address width
//   CNT_W  : hazard stall counter width
interface dx_hazard_if #(
  parameter int REG_AW = 3,
  parameter int CNT_W  = 8
);
  logic              fd_valid;
  logic [REG_AW-1:0] fd_rs;
  logic              fd_rs_used;
  logic [REG_AW-1:0] fd_rt;
  logic              fd_rt_used;
  logic              fd_wr_en;
  logic [REG_AW-1:0] fd_wr_reg;
  logic              fd_is_load;
  logic              br_taken;
  logic              mem_stall;

  logic              pc_stall;
  logic              fd_stall;
  logic              dx_bubble;
  logic              fd_flush;
  logic [CNT_W-1:0]  hazard_cnt;

  modport master (
    output fd_valid, fd_rs, fd_rs_used, fd_rt, fd_rt_used,
           fd_wr_en, fd_wr_reg, fd_is_load, br_taken, mem_stall,
    input  pc_stall, fd_stall, dx_bubble, fd_flush, hazard_cnt
  );

  modport slave (
    input  fd_valid, fd_rs, fd_rs_used, fd_rt, fd_rt_used,
           fd_wr_en, fd_wr_reg, fd_is_load, br_taken, mem_stall,
    output pc_stall, fd_stall, dx_bubble, fd_flush, hazard_cnt
  );
endinterface

// File: rtl/dx_hazard_ctrl.sv
// dx_hazard_ctrl
//   Control end of the decode->execute pipeline register. Keeps a 3-slot
//   scoreboard of in-flight register writers (DX, XM, MW), detects RAW
//   hazards against the decode-stage sources and decides whether the FD
//   instruction advances, is held (bubble into DX) or is flushed.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-low reset
//   hz (slave) : decode-stage fields, br_taken, mem_stall in;
//                pc_stall, fd_stall, dx_bubble, fd_flush, hazard_cnt out
//
// Parameters
//   REG_AW : register address width (must match the interface instance)
//   CNT_W  : width of the saturating hazard stall counter
//
// Build option
//   DX_HAZARD_FORWARDING_EN : execute forwards from XM and MW, so only a
//   load sitting in DX causes a (single-cycle) stall. Undefined: any
//   writer in DX or XM stalls the dependent instruction.
module dx_hazard_ctrl #(
  parameter int REG_AW = 3,
  parameter int CNT_W  = 8
) (
  input logic       clk,
  input logic       rst,
  dx_hazard_if.slave hz
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] wr_reg;
    logic              is_load;
  } slot_t;

  slot_t            dx_q, dx_d;
  slot_t            xm_q, xm_d;
  slot_t            mw_q, mw_d;
  logic [CNT_W-1:0] hazard_cnt_q, hazard_cnt_d;

  logic             match_dx;
  logic             raw_haz;
  logic             pc_stall;
  logic             fd_stall;
  logic             dx_bubble;
  logic             fd_flush;

  function automatic logic src_match(
    input slot_t             s,
    input logic              rs_used,
    input logic [REG_AW-1:0] rs,
    input logic              rt_used,
    input logic [REG_AW-1:0] rt
  );
    return s.valid && ((rs_used && (rs == s.wr_reg)) ||
                       (rt_used && (rt == s.wr_reg)));
  endfunction

  // MW is never compared: the register file bypasses a same-cycle write to
  // the read port. The slot is still tracked so the scoreboard mirrors the
  // pipe, which keeps it easy to probe in simulation.
  logic mw_unused;
  assign mw_unused = ^mw_q;

  assign match_dx = src_match(dx_q, hz.fd_rs_used, hz.fd_rs,
                              hz.fd_rt_used, hz.fd_rt);

`ifdef DX_HAZARD_FORWARDING_EN
  // Only load-use remains: the loaded value is not available until after MEM.
  assign raw_haz = hz.fd_valid && match_dx && dx_q.is_load;
`else
  logic match_xm;
  assign match_xm = src_match(xm_q, hz.fd_rs_used, hz.fd_rs,
                              hz.fd_rt_used, hz.fd_rt);
  assign raw_haz  = hz.fd_valid && (match_dx || match_xm);
`endif

  always_comb begin
    pc_stall     = 1'b0;
    fd_stall     = 1'b0;
    dx_bubble    = 1'b0;
    fd_flush     = 1'b0;
    dx_d         = dx_q;
    xm_d         = xm_q;
    mw_d         = mw_q;
    hazard_cnt_d = hazard_cnt_q;

    if (!rst) begin
      // outputs stay 0; the register block clears state on this edge
    end else if (hz.mem_stall) begin
      // whole pipe frozen, including any pending redirect
      pc_stall = 1'b1;
      fd_stall = 1'b1;
    end else begin
      mw_d = xm_q;
      xm_d = dx_q;
      if (hz.br_taken) begin
        // the FD instruction is on the wrong path, so its hazard is moot
        fd_flush  = 1'b1;
        dx_bubble = 1'b1;
        dx_d      = '0;
      end else if (raw_haz) begin
        pc_stall  = 1'b1;
        fd_stall  = 1'b1;
        dx_bubble = 1'b1;
        dx_d      = '0;
        if (hazard_cnt_q != {CNT_W{1'b1}}) begin
          hazard_cnt_d = hazard_cnt_q + CNT_W'(1);
        end
      end else begin
        dx_d.valid   = hz.fd_valid && hz.fd_wr_en;
        dx_d.wr_reg  = hz.fd_wr_reg;
        dx_d.is_load = hz.fd_valid && hz.fd_wr_en && hz.fd_is_load;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dx_q         <= '0;
      xm_q         <= '0;
      mw_q         <= '0;
      hazard_cnt_q <= '0;
    end else begin
      dx_q         <= dx_d;
      xm_q         <= xm_d;
      mw_q         <= mw_d;
      hazard_cnt_q <= hazard_cnt_d;
    end
  end

  assign hz.pc_stall   = pc_stall;
  assign hz.fd_stall   = fd_stall;
  assign hz.dx_bubble  = dx_bubble;
  assign hz.fd_flush   = fd_flush;
  assign hz.hazard_cnt = hazard_cnt_q;

endmodule

// File: tb/tb_dx_hazard_ctrl.sv
// Bench for dx_hazard_ctrl: two instances (8-bit and 2-bit counters) share
// stimulus. The reference model tracks, per register, how many pipeline
// advances have passed since its youngest in-flight writer entered DX.
module tb_dx_hazard_ctrl;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dx_hazard_if #(.REG_AW(AW), .CNT_W(8)) hz ();
  dx_hazard_if #(.REG_AW(AW), .CNT_W(2)) hs ();

  dx_hazard_ctrl #(.REG_AW(AW), .CNT_W(8)) u_dut (.clk(clk), .rst(rst), .hz(hz));
  dx_hazard_ctrl #(.REG_AW(AW), .CNT_W(2)) u_sat (.clk(clk), .rst(rst), .hz(hs));

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  int age [8];
  bit ld  [8];
  int m_cnt;
  int m_sat;

`ifdef DX_HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit hit(input int r);
    if (FWD) return (age[r] == 0) && ld[r];
    return age[r] <= 1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      age[i] = 99;
      ld[i]  = 1'b0;
    end
    m_cnt = 0;
    m_sat = 0;
  endtask

  // One clock cycle: drive at the falling edge, check 1ns later, advance model at the rising edge.
  task automatic cyc(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                     input bit we, input int wr, input bit isld, input bit br, input bit ms,
                     input bit r);
    bit haz, e_pc, e_bub, e_fl;
    rst = r;
    hz.fd_valid = v;  hs.fd_valid = v;
    hz.fd_rs = AW'(rs); hs.fd_rs = AW'(rs);
    hz.fd_rs_used = rsu; hs.fd_rs_used = rsu;
    hz.fd_rt = AW'(rt); hs.fd_rt = AW'(rt);
    hz.fd_rt_used = rtu; hs.fd_rt_used = rtu;
    hz.fd_wr_en = we; hs.fd_wr_en = we;
    hz.fd_wr_reg = AW'(wr); hs.fd_wr_reg = AW'(wr);
    hz.fd_is_load = isld; hs.fd_is_load = isld;
    hz.br_taken = br; hs.br_taken = br;
    hz.mem_stall = ms; hs.mem_stall = ms;
    #1;
    haz = v && ((rsu && hit(rs)) || (rtu && hit(rt)));
    e_pc = 0; e_bub = 0; e_fl = 0;
    if (!r) begin
    end else if (ms) e_pc = 1;
    else if (br) begin e_fl = 1; e_bub = 1; end
    else if (haz) begin e_pc = 1; e_bub = 1; end
    chk("pc_stall", hz.pc_stall, e_pc);
    chk("fd_stall", hz.fd_stall, e_pc);
    chk("dx_bubble", hz.dx_bubble, e_bub);
    chk("fd_flush", hz.fd_flush, e_fl);
    chk("hazard_cnt", hz.hazard_cnt, m_cnt);
    chk("sat_pc_stall", hs.pc_stall, e_pc);
    chk("sat_dx_bubble", hs.dx_bubble, e_bub);
    chk("sat_fd_flush", hs.fd_flush, e_fl);
    chk("sat_hazard_cnt", hs.hazard_cnt, m_sat);
    @(posedge clk);
    if (!r) model_clear();
    else if (!ms) begin
      for (int i = 0; i < 8; i++) if (age[i] < 99) age[i]++;
      if (!br && haz) begin
        if (m_cnt < 255) m_cnt++;
        if (m_sat < 3) m_sat++;
      end
      if (!br && !haz && v && we) begin
        age[wr] = 0;
        ld[wr]  = isld;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    model_clear();
    // reset, then independent reader with nothing in flight
    cyc(0,0,0,0,0,0,0,0,0,0,0);
    cyc(0,0,0,0,0,0,0,0,0,0,0);
    for (int i = 0; i < 10; i++) cyc(1,3,1,4,1,0,0,0,0,0,1);
    chk("idle_cnt", hz.hazard_cnt, 0);

    // ADD r2 then reader of r2
    cyc(1,0,0,0,0,1,2,0,0,0,1);
    for (int i = 0; i < 3; i++) cyc(1,2,1,0,0,0,0,0,0,0,1);
    chk("add_use_cnt", hz.hazard_cnt, FWD ? 0 : 2);

    // load-use and ALU-use on r5
    cyc(0,0,0,0,0,0,0,0,0,0,0);
    cyc(1,0,0,0,0,1,5,1,0,0,1);
    for (int i = 0; i < 3; i++) cyc(1,0,0,5,1,0,0,0,0,0,1);
    chk("load_use_cnt", hz.hazard_cnt, FWD ? 1 : 2);
    cyc(1,0,0,0,0,1,5,0,0,0,1);
    for (int i = 0; i < 3; i++) cyc(1,0,0,5,1,0,0,0,0,0,1);
    chk("alu_use_cnt", hz.hazard_cnt, FWD ? 1 : 4);

    // hazard together with a taken branch: flush wins, no count
    cyc(0,0,0,0,0,0,0,0,0,0,0);
    cyc(1,0,0,0,0,1,4,1,0,0,1);
    cyc(1,4,1,0,0,0,0,0,1,0,1);
    chk("br_cnt", hz.hazard_cnt, 0);

    // producer in DX, memory stall for 3 cycles, then resolve
    cyc(1,0,0,0,0,1,3,0,0,0,1);
    for (int i = 0; i < 3; i++) cyc(1,3,1,0,0,0,0,0,0,1,1);
    for (int i = 0; i < 3; i++) cyc(1,3,1,0,0,0,0,0,0,0,1);
    chk("mem_stall_cnt", hz.hazard_cnt, FWD ? 0 : 2);

    // saturation on the 2-bit counter
    cyc(0,0,0,0,0,0,0,0,0,0,0);
    cyc(1,0,0,0,0,1,1,0,0,0,1);
    for (int i = 0; i < 9; i++) cyc(1,1,1,0,0,1,1,0,0,0,1);
    chk("sat_cnt_main", hz.hazard_cnt, FWD ? 0 : 6);
    chk("sat_cnt_small", hs.hazard_cnt, FWD ? 0 : 3);

    // reset asserted in the middle of a stall
    cyc(1,0,0,0,0,1,6,1,0,0,1);
    cyc(1,6,1,0,0,0,0,0,0,0,1);
    cyc(1,6,1,0,0,0,0,0,0,0,0);
    chk("rst_cnt", hz.hazard_cnt, 0);
    cyc(1,6,1,0,0,0,0,0,0,0,1);
    chk("post_rst_cnt", hz.hazard_cnt, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(9) != 0, $urandom_range(7), $urandom_range(1), $urandom_range(7),
          $urandom_range(1), $urandom_range(2) != 0, $urandom_range(7), $urandom_range(2) == 0,
          $urandom_range(9) == 0, $urandom_range(6) == 0, $urandom_range(49) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
